id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_pkg.sv | 47 ++++
 rtl/id_ex_reg_wb_bypass.sv | 24 ++
 rtl/id_ex_reg.sv | 154 +++++++++++++++
 tb/tb_id_ex_reg.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: control-word layout, ALU encodings and the
// bubble constant used by the ID/EX stage register.
package id_ex_reg_pkg;

  localparam int CTRL_W = 12;

  // Bit positions inside the 12-bit control word
  // {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jal, Jalr, ALUctl[3:0]}
  localparam int CTRL_REGWRITE = 11;
  localparam int CTRL_MEMREAD  = 10;
  localparam int CTRL_MEMWRITE = 9;
  localparam int CTRL_MEMTOREG = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_JAL      = 5;
  localparam int CTRL_JALR     = 4;
  localparam int CTRL_ALU_HI   = 3;
  localparam int CTRL_ALU_LO   = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_LUI  = 4'hA
  } alu_ctl_e;

  // A bubble carries no side effects: every control bit cleared
  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when a write-back to wb_rd should replace the operand read from rs_idx
  function automatic logic bypass_hit(input logic wb_we, input logic [4:0] wb_rd,
                                      input logic [4:0] rs_idx);
    return wb_we && (wb_rd == rs_idx) && (rs_idx != REG_X0);
  endfunction

endpackage

// File: rtl/id_ex_reg_wb_bypass.sv
// Write-back operand bypass for one source register. Selects the write-back
// bus when it targets the same non-zero register, else passes the operand.
module wb_bypass
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic [4:0]      rs_idx_i,
  input  logic [XLEN-1:0] rs_data_i,
  output logic [XLEN-1:0] rs_data_o
);

  // x0 is never overridden so its operand stays as supplied
  always_comb begin
    rs_data_o = rs_data_i;
    if (bypass_hit(wb_we_i, wb_rd_i, rs_idx_i)) begin
      rs_data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion, hazard hold and write-back
// operand bypass. All outputs come straight from flops.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_id,
  input  logic [XLEN-1:0]   PC_id,
  input  logic [XLEN-1:0]   Imm_id,
  input  logic [XLEN-1:0]   Rs1_data_id,
  input  logic [XLEN-1:0]   Rs2_data_id,
  input  logic [4:0]        Rs1_id,
  input  logic [4:0]        Rs2_id,
  input  logic [4:0]        Rd_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              RegWrite_mem_wb_o,
  input  logic [4:0]        Rd_mem_wb_o,
  input  logic [XLEN-1:0]   WB_data,
  output logic [XLEN-1:0]   PC_id_ex_o,
  output logic [XLEN-1:0]   Imm_id_ex_o,
  output logic [XLEN-1:0]   Rs1_data_id_ex_o,
  output logic [XLEN-1:0]   Rs2_data_id_ex_o,
  output logic [4:0]        Rs1_id_ex_o,
  output logic [4:0]        Rs2_id_ex_o,
  output logic [4:0]        Rd_id_ex_o,
  output logic [CTRL_W-1:0] ctrl_id_ex_o,
  output logic              valid_id_ex_o,
  output logic              RegWrite_id_ex_o,
  output logic              MemRead_id_ex_o,
  output logic              MemWrite_id_ex_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            valid_q, valid_d;

  logic [4:0]      byp1_idx, byp2_idx;
  logic [XLEN-1:0] byp1_in, byp2_in;
  logic [XLEN-1:0] byp1_out, byp2_out;

  // While held, the bypass looks at the stored operand so a late write-back
  // refreshes it; otherwise it looks at the incoming ID operand.
  always_comb begin
    byp1_idx = stall ? rs1_q      : Rs1_id;
    byp2_idx = stall ? rs2_q      : Rs2_id;
    byp1_in  = stall ? rs1_data_q : Rs1_data_id;
    byp2_in  = stall ? rs2_data_q : Rs2_data_id;
  end

  wb_bypass #(.XLEN(XLEN)) u_byp_rs1 (
    .wb_we_i   (RegWrite_mem_wb_o),
    .wb_rd_i   (Rd_mem_wb_o),
    .wb_data_i (WB_data),
    .rs_idx_i  (byp1_idx),
    .rs_data_i (byp1_in),
    .rs_data_o (byp1_out)
  );

  wb_bypass #(.XLEN(XLEN)) u_byp_rs2 (
    .wb_we_i   (RegWrite_mem_wb_o),
    .wb_rd_i   (Rd_mem_wb_o),
    .wb_data_i (WB_data),
    .rs_idx_i  (byp2_idx),
    .rs_data_i (byp2_in),
    .rs_data_o (byp2_out)
  );

  // Next-state selection: flush beats stall beats load
  always_comb begin
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    valid_d    = valid_q;
    if (flush) begin
      pc_d       = '0;
      imm_d      = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      rs1_d      = REG_X0;
      rs2_d      = REG_X0;
      rd_d       = REG_X0;
      ctrl_d     = CTRL_NOP;
      valid_d    = 1'b0;
    end else if (stall) begin
      rs1_data_d = byp1_out;
      rs2_data_d = byp2_out;
    end else begin
      pc_d       = PC_id;
      imm_d      = Imm_id;
      rs1_data_d = byp1_out;
      rs2_data_d = byp2_out;
      rs1_d      = Rs1_id;
      rs2_d      = Rs2_id;
      rd_d       = Rd_id;
      ctrl_d     = valid_id ? ctrl_id : CTRL_NOP;
      valid_d    = valid_id;
    end
  end

  // Stage register with synchronous reset overriding everything
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= REG_X0;
      rs2_q      <= REG_X0;
      rd_q       <= REG_X0;
      ctrl_q     <= CTRL_NOP;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
    end
  end

  assign PC_id_ex_o       = pc_q;
  assign Imm_id_ex_o      = imm_q;
  assign Rs1_data_id_ex_o = rs1_data_q;
  assign Rs2_data_id_ex_o = rs2_data_q;
  assign Rs1_id_ex_o      = rs1_q;
  assign Rs2_id_ex_o      = rs2_q;
  assign Rd_id_ex_o       = rd_q;
  assign ctrl_id_ex_o     = ctrl_q;
  assign valid_id_ex_o    = valid_q;
  assign RegWrite_id_ex_o = ctrl_q[CTRL_REGWRITE];
  assign MemRead_id_ex_o  = ctrl_q[CTRL_MEMREAD];
  assign MemWrite_id_ex_o = ctrl_q[CTRL_MEMWRITE];

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed table-driven bench for the ID/EX stage register.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_id;
  logic [31:0] PC_id, Imm_id, Rs1_data_id, Rs2_data_id;
  logic [4:0]  Rs1_id, Rs2_id, Rd_id;
  logic [11:0] ctrl_id;
  logic        RegWrite_mem_wb_o;
  logic [4:0]  Rd_mem_wb_o;
  logic [31:0] WB_data;
  logic [31:0] PC_id_ex_o, Imm_id_ex_o, Rs1_data_id_ex_o, Rs2_data_id_ex_o;
  logic [4:0]  Rs1_id_ex_o, Rs2_id_ex_o, Rd_id_ex_o;
  logic [11:0] ctrl_id_ex_o;
  logic        valid_id_ex_o, RegWrite_id_ex_o, MemRead_id_ex_o, MemWrite_id_ex_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_id(valid_id),
    .PC_id(PC_id), .Imm_id(Imm_id), .Rs1_data_id(Rs1_data_id), .Rs2_data_id(Rs2_data_id),
    .Rs1_id(Rs1_id), .Rs2_id(Rs2_id), .Rd_id(Rd_id), .ctrl_id(ctrl_id),
    .RegWrite_mem_wb_o(RegWrite_mem_wb_o), .Rd_mem_wb_o(Rd_mem_wb_o), .WB_data(WB_data),
    .PC_id_ex_o(PC_id_ex_o), .Imm_id_ex_o(Imm_id_ex_o),
    .Rs1_data_id_ex_o(Rs1_data_id_ex_o), .Rs2_data_id_ex_o(Rs2_data_id_ex_o),
    .Rs1_id_ex_o(Rs1_id_ex_o), .Rs2_id_ex_o(Rs2_id_ex_o), .Rd_id_ex_o(Rd_id_ex_o),
    .ctrl_id_ex_o(ctrl_id_ex_o), .valid_id_ex_o(valid_id_ex_o),
    .RegWrite_id_ex_o(RegWrite_id_ex_o), .MemRead_id_ex_o(MemRead_id_ex_o),
    .MemWrite_id_ex_o(MemWrite_id_ex_o)
  );

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] ctrl;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic [31:0] e_pc, e_imm, e_d1, e_d2;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [11:0] e_ctrl;
    logic        e_valid;
    logic        chk_all;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; flush = v.flush; valid_id = v.valid;
    PC_id = v.pc; Imm_id = v.imm; Rs1_data_id = v.d1; Rs2_data_id = v.d2;
    Rs1_id = v.rs1; Rs2_id = v.rs2; Rd_id = v.rd; ctrl_id = v.ctrl;
    RegWrite_mem_wb_o = v.we; Rd_mem_wb_o = v.wrd; WB_data = v.wdata;
  endtask

  task automatic compare(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    check({p, ".ctrl"}, {20'd0, ctrl_id_ex_o}, {20'd0, v.e_ctrl});
    check({p, ".valid"}, {31'd0, valid_id_ex_o}, {31'd0, v.e_valid});
    check({p, ".RegWrite"}, {31'd0, RegWrite_id_ex_o}, {31'd0, v.e_ctrl[11]});
    check({p, ".MemRead"}, {31'd0, MemRead_id_ex_o}, {31'd0, v.e_ctrl[10]});
    check({p, ".MemWrite"}, {31'd0, MemWrite_id_ex_o}, {31'd0, v.e_ctrl[9]});
    if (v.chk_all) begin
      check({p, ".pc"}, PC_id_ex_o, v.e_pc);
      check({p, ".imm"}, Imm_id_ex_o, v.e_imm);
      check({p, ".rs1_data"}, Rs1_data_id_ex_o, v.e_d1);
      check({p, ".rs2_data"}, Rs2_data_id_ex_o, v.e_d2);
      check({p, ".rs1"}, {27'd0, Rs1_id_ex_o}, {27'd0, v.e_rs1});
      check({p, ".rs2"}, {27'd0, Rs2_id_ex_o}, {27'd0, v.e_rs2});
      check({p, ".rd"}, {27'd0, Rd_id_ex_o}, {27'd0, v.e_rd});
    end
  endtask

  initial begin
    //          rst   stall flush valid pc         imm        d1         d2         rs1   rs2   rd     ctrl     we    wrd   wdata        e_pc       e_imm      e_d1       e_d2       e_rs1 e_rs2 e_rd   e_ctrl   e_v   all
    // reset
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h5,    32'h6,    32'h7,    5'd1, 5'd2, 5'd3,  12'hFFF, 1'b0, 5'd0, 32'h0,     32'h0,    32'h0,    32'h0,    32'h0,    5'd0, 5'd0, 5'd0,  12'h000, 1'b0, 1'b1};
    // load lw x5 at 0x100
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  32'h4,    32'hA,    32'hB,    5'd1, 5'd2, 5'd5,  12'hD80, 1'b0, 5'd0, 32'h0,     32'h100,  32'h4,    32'hA,    32'hB,    5'd1, 5'd2, 5'd5,  12'hD80, 1'b1, 1'b1};
    // flush -> bubble
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h104,  32'h8,    32'hC,    32'hD,    5'd3, 5'd4, 5'd6,  12'h800, 1'b0, 5'd0, 32'h0,     32'h0,    32'h0,    32'h0,    32'h0,    5'd0, 5'd0, 5'd0,  12'h000, 1'b0, 1'b1};
    // load with Rs1=x7, Rs2=x0
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h200,  32'h10,   32'h70,   32'h0,    5'd7, 5'd0, 5'd9,  12'h802, 1'b0, 5'd0, 32'h0,     32'h200,  32'h10,   32'h70,   32'h0,    5'd7, 5'd0, 5'd9,  12'h802, 1'b1, 1'b1};
    // stall, WB x7=0xDEAD refreshes held Rs1 data
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h300,  32'h20,   32'h1,    32'h2,    5'd1, 5'd2, 5'd1,  12'h8A0, 1'b1, 5'd7, 32'hDEAD,  32'h200,  32'h10,   32'hDEAD, 32'h0,    5'd7, 5'd0, 5'd9,  12'h802, 1'b1, 1'b1};
    // stall, WB to x0 must not touch held x0 operand
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h300,  32'h20,   32'h1,    32'h2,    5'd1, 5'd2, 5'd1,  12'h8A0, 1'b1, 5'd0, 32'h55,    32'h200,  32'h10,   32'hDEAD, 32'h0,    5'd7, 5'd0, 5'd9,  12'h802, 1'b1, 1'b1};
    // load, Rs2=x0 while WB writes x0=0x55
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h400,  32'h14,   32'h40,   32'h0,    5'd4, 5'd0, 5'd6,  12'h880, 1'b1, 5'd0, 32'h55,    32'h400,  32'h14,   32'h40,   32'h0,    5'd4, 5'd0, 5'd6,  12'h880, 1'b1, 1'b1};
    // load bypass: x3 written back same cycle
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h500,  32'h18,   32'h11,   32'h33,   5'd3, 5'd3, 5'd3,  12'h800, 1'b1, 5'd3, 32'h22,    32'h500,  32'h18,   32'h22,   32'h22,   5'd3, 5'd3, 5'd3,  12'h800, 1'b1, 1'b1};
    // matching Rd but RegWrite low: no bypass
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h504,  32'h1C,   32'h11,   32'h55,   5'd3, 5'd5, 5'd10, 12'h881, 1'b0, 5'd3, 32'h99,    32'h504,  32'h1C,   32'h11,   32'h55,   5'd3, 5'd5, 5'd10, 12'h881, 1'b1, 1'b1};
    // stall refresh of Rs2 only
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h600,  32'h0,    32'h0,    32'h0,    5'd0, 5'd0, 5'd0,  12'h000, 1'b1, 5'd5, 32'h77,    32'h504,  32'h1C,   32'h11,   32'h77,   5'd3, 5'd5, 5'd10, 12'h881, 1'b1, 1'b1};
    // stall + flush -> bubble
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h608,  32'h3,    32'h4,    32'h5,    5'd3, 5'd5, 5'd7,  12'h8FF, 1'b1, 5'd3, 32'h99,    32'h0,    32'h0,    32'h0,    32'h0,    5'd0, 5'd0, 5'd0,  12'h000, 1'b0, 1'b1};
    // load with valid_id=0 -> ctrl forced to NOP, valid low
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h600,  32'h6,    32'h1,    32'h2,    5'd1, 5'd2, 5'd3,  12'hFFF, 1'b0, 5'd0, 32'h0,     32'h600,  32'h6,    32'h1,    32'h2,    5'd1, 5'd2, 5'd3,  12'h000, 1'b0, 1'b0};
    // load store-ish word
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h700,  32'h8,    32'h90,   32'hA0,   5'd9, 5'd10,5'd8,  12'h600, 1'b0, 5'd0, 32'h0,     32'h700,  32'h8,    32'h90,   32'hA0,   5'd9, 5'd10,5'd8,  12'h600, 1'b1, 1'b1};
    // rst with stall
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h704,  32'h9,    32'h1,    32'h2,    5'd9, 5'd10,5'd8,  12'h600, 1'b1, 5'd9, 32'h1,     32'h0,    32'h0,    32'h0,    32'h0,    5'd0, 5'd0, 5'd0,  12'h000, 1'b0, 1'b1};
    // first edge after reset loads normally
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h800,  32'hC,    32'h21,   32'h41,   5'd2, 5'd4, 5'd1,  12'h8A3, 1'b0, 5'd0, 32'h0,     32'h800,  32'hC,    32'h21,   32'h41,   5'd2, 5'd4, 5'd1,  12'h8A3, 1'b1, 1'b1};
    // rst with flush
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h804,  32'hD,    32'h22,   32'h42,   5'd3, 5'd5, 5'd2,  12'h800, 1'b0, 5'd0, 32'h0,     32'h0,    32'h0,    32'h0,    32'h0,    5'd0, 5'd0, 5'd0,  12'h000, 1'b0, 1'b1};

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      compare(i, tbl[i]);
      @(negedge clk);
    end

    // Multi-cycle hold: load, stall three cycles without write-back, release
    drive(tbl[12]);
    @(posedge clk); #1;
    @(negedge clk);
    stall = 1'b1; PC_id = 32'hBAD0; Rd_id = 5'd31; ctrl_id = 12'h0FF; valid_id = 1'b0;
    Rs1_data_id = 32'hBAD1; RegWrite_mem_wb_o = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d.pc", c), PC_id_ex_o, 32'h700);
      check($sformatf("hold%0d.rd", c), {27'd0, Rd_id_ex_o}, 32'd8);
      check($sformatf("hold%0d.ctrl", c), {20'd0, ctrl_id_ex_o}, 32'h600);
      check($sformatf("hold%0d.valid", c), {31'd0, valid_id_ex_o}, 32'd1);
      check($sformatf("hold%0d.rs1_data", c), Rs1_data_id_ex_o, 32'h90);
      @(negedge clk);
    end
    stall = 1'b0; valid_id = 1'b1; ctrl_id = 12'h803;
    @(posedge clk); #1;
    check("release.pc", PC_id_ex_o, 32'hBAD0);
    check("release.rd", {27'd0, Rd_id_ex_o}, 32'd31);
    check("release.ctrl", {20'd0, ctrl_id_ex_o}, 32'h803);
    check("release.rs1_data", Rs1_data_id_ex_o, 32'hBAD1);
    @(negedge clk);

    // Load bypass must not fire into an x0 Rs1 either
    Rs1_id = 5'd0; Rs1_data_id = 32'h0; RegWrite_mem_wb_o = 1'b1; Rd_mem_wb_o = 5'd0;
    WB_data = 32'h55;
    @(posedge clk); #1;
    check("x0rs1.rs1_data", Rs1_data_id_ex_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
